// File: rtl/uart_rx.sv
// uart_rx: 8E1 serial receiver with an OVERSAMPLE-times rx_tick enable.
// Ports: clock, reset (async, active-high), rx_tick, rx in;
//   rx_data, rx_valid, parity_err, frame_err out.
// Macro UART_RX_PARITY_CHECK_EN enables the parity check (else parity_err=0).
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_tick,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          rx_meta;
    logic          rx_sync;
    logic          prev_sample;
    logic [TW-1:0] tcnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    shreg;

    logic start_det;
    logic half_hit;
    logic bit_hit;
    logic shift_en;
    logic done;
    logic tcnt_clr;
    logic bit_clr;

    assign start_det = !rx_sync && prev_sample;
    assign half_hit  = (tcnt == HALF);
    assign bit_hit   = (tcnt == LAST);

    // Synchroniser idles high so reset never looks like a start edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            prev_sample <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            if (rx_tick)
                prev_sample <= rx_sync;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (rx_tick) begin
            unique case (state)
                IDLE:    if (start_det) state_nxt = START;
                START:   if (half_hit) state_nxt = rx_sync ? IDLE : DATA;
                DATA:    if (bit_hit && bit_cnt == 4'd8) state_nxt = STOP;
                STOP:    if (bit_hit) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // tcnt restarts on every state entry and at each bit boundary.
    always_comb begin
        shift_en = rx_tick && (state == DATA) && bit_hit;
        done     = rx_tick && (state == STOP) && bit_hit;
        bit_clr  = rx_tick && (state == START) && half_hit;
        tcnt_clr = rx_tick && ((state_nxt != state) ||
                               (state == IDLE) || bit_hit);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tcnt      <= '0;
            bit_cnt   <= 4'd0;
            shreg     <= 9'd0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid <= done;
            if (tcnt_clr)
                tcnt <= '0;
            else if (rx_tick)
                tcnt <= tcnt + 1'b1;
            if (bit_clr)
                bit_cnt <= 4'd0;
            else if (shift_en && bit_cnt != 4'd8)
                bit_cnt <= bit_cnt + 4'd1;
            if (shift_en)
                shreg <= {rx_sync, shreg[8:1]};
            if (done) begin
                rx_data   <= shreg[7:0];
                frame_err <= ~rx_sync;
            end
        end
    end

`ifdef UART_RX_PARITY_CHECK_EN
    // Data plus even parity bit XORs to zero on a clean frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            parity_err <= 1'b0;
        else if (done)
            parity_err <= ^shreg;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed checks of uart_rx against a
// frame-level reference model.
module tb_uart_rx;

    localparam int OS = 16;

`ifdef UART_RX_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
    } rec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;

    int total = 0;
    int bad = 0;

    rec_t got_q[$];
    rec_t exp_q[$];

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_tick    (rx_tick),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 clock = ~clock;

    // Irregular tick spacing, including back-to-back ticks.
    initial forever begin
        @(posedge clock);
        #1;
        rx_tick = ($urandom_range(0, 2) != 0);
    end

    // Every cycle rx_valid is high yields one record.
    always @(negedge clock) begin
        if (rx_valid) begin
            rec_t r;
            r.d = rx_data;
            r.p = parity_err;
            r.f = frame_err;
            got_q.push_back(r);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Returns at the negedge preceding the n-th tick edge.
    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(negedge clock);
            if (rx_tick) k++;
        end
    endtask

    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            rx = fr[i];
            wait_ticks(OS);
        end
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        wait_ticks(n * OS);
    endtask

    // Model: byte as sent; parity error when data^parity is odd;
    // frame error when the stop bit is low.
    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic s);
        rec_t e;
        send_bits({s, p, d, 1'b0}, 11);
        e.d = d;
        e.p = PCHK ? ((^d) ^ p) : 1'b0;
        e.f = ~s;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clock);
        total++;
        if (rx_data !== 8'h00) begin
            bad++; $display("FAIL rst_data got=%h exp=00", rx_data);
        end
        total++;
        if (rx_valid !== 1'b0) begin
            bad++; $display("FAIL rst_valid got=%b exp=0", rx_valid);
        end
        total++;
        if (parity_err !== 1'b0) begin
            bad++; $display("FAIL rst_perr got=%b exp=0", parity_err);
        end
        total++;
        if (frame_err !== 1'b0) begin
            bad++; $display("FAIL rst_ferr got=%b exp=0", frame_err);
        end
        reset = 1'b0;
        idle_bits(2);
    endtask

    task automatic test_good();
        got_q.delete();
        send_frame(8'hA5, 1'b0, 1'b1);
        idle_bits(2);
        total++;
        if (got_q.size() !== 1) begin
            bad++; $display("FAIL good_cnt got=%0d exp=1", got_q.size());
        end
        total++;
        if (got_q[0] !== {8'hA5, 1'b0, 1'b0}) begin
            bad++; $display("FAIL good_rec got=%h exp=%h",
                            got_q[0], {8'hA5, 2'b00});
        end
    endtask

    task automatic test_parity();
        got_q.delete();
        send_frame(8'h01, 1'b0, 1'b1);
        idle_bits(2);
        total++;
        if (got_q.size() !== 1) begin
            bad++; $display("FAIL par_cnt got=%0d exp=1", got_q.size());
        end
        total++;
        if (got_q[0] !== {8'h01, PCHK, 1'b0}) begin
            bad++; $display("FAIL par_rec got=%h exp=%h",
                            got_q[0], {8'h01, PCHK, 1'b0});
        end
    endtask

    task automatic test_break();
        got_q.delete();
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        wait_ticks(40 * OS);
        total++;
        if (got_q.size() !== 1) begin
            bad++; $display("FAIL brk_cnt got=%0d exp=1", got_q.size());
        end
        total++;
        if (got_q[0] !== {8'h3C, 1'b0, 1'b1}) begin
            bad++; $display("FAIL brk_rec got=%h exp=%h",
                            got_q[0], {8'h3C, 1'b0, 1'b1});
        end
        idle_bits(2);
        send_frame(8'h3C, 1'b0, 1'b1);
        idle_bits(2);
        total++;
        if (got_q.size() !== 2) begin
            bad++; $display("FAIL brk_cnt2 got=%0d exp=2", got_q.size());
        end
        total++;
        if (got_q[1] !== {8'h3C, 1'b0, 1'b0}) begin
            bad++; $display("FAIL brk_rec2 got=%h exp=%h",
                            got_q[1], {8'h3C, 2'b00});
        end
    endtask

    task automatic test_glitch();
        got_q.delete();
        rx = 1'b0;
        wait_ticks(4);
        idle_bits(3);
        total++;
        if (got_q.size() !== 0) begin
            bad++; $display("FAIL glt_cnt got=%0d exp=0", got_q.size());
        end
        send_frame(8'h5A, 1'b0, 1'b1);
        idle_bits(2);
        total++;
        if (got_q.size() !== 1) begin
            bad++; $display("FAIL glt_cnt2 got=%0d exp=1", got_q.size());
        end
        total++;
        if (got_q[0] !== {8'h5A, 2'b00}) begin
            bad++; $display("FAIL glt_rec got=%h exp=%h",
                            got_q[0], {8'h5A, 2'b00});
        end
    endtask

    task automatic test_back_to_back();
        got_q.delete();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle_bits(2);
        total++;
        if (got_q.size() !== 2) begin
            bad++; $display("FAIL b2b_cnt got=%0d exp=2", got_q.size());
        end
        total++;
        if (got_q[0] !== {8'h00, 2'b00}) begin
            bad++; $display("FAIL b2b_rec0 got=%h exp=000", got_q[0]);
        end
        total++;
        if (got_q[1] !== {8'hFF, 2'b00}) begin
            bad++; $display("FAIL b2b_rec1 got=%h exp=3fc", got_q[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] fr;
        send_frame(8'h3C, 1'b1, 1'b0);
        idle_bits(2);
        got_q.delete();
        fr = {1'b1, 1'b0, 8'h96, 1'b0};
        send_bits(fr, 5);
        rx = fr[5];
        wait_ticks(OS / 2);
        @(negedge clock);
        reset = 1'b1;
        #1;
        total++;
        if ({rx_data, rx_valid, parity_err, frame_err} !== 11'd0) begin
            bad++; $display("FAIL mid_rst got=%h/%b%b%b exp=00/000",
                            rx_data, rx_valid, parity_err, frame_err);
        end
        rx = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        idle_bits(12);
        total++;
        if (got_q.size() !== 0) begin
            bad++; $display("FAIL mid_cnt got=%0d exp=0", got_q.size());
        end
        send_frame(8'hC3, 1'b0, 1'b1);
        idle_bits(2);
        total++;
        if (got_q.size() !== 1) begin
            bad++; $display("FAIL mid_cnt2 got=%0d exp=1", got_q.size());
        end
        total++;
        if (got_q[0] !== {8'hC3, 2'b00}) begin
            bad++; $display("FAIL mid_rec got=%h exp=%h",
                            got_q[0], {8'hC3, 2'b00});
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       p;
        logic       s;
        got_q.delete();
        exp_q.delete();
        repeat (25) begin
            d = 8'($urandom);
            p = (^d) ^ ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 4) != 0);
            send_frame(d, p, s);
            if (!s || $urandom_range(0, 1) == 1)
                idle_bits(1);
        end
        idle_bits(2);
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL rnd_cnt got=%0d exp=%0d",
                            got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL rnd_rec%0d got=%h exp=%h",
                                i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_parity();
        test_break();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
